// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access size
// encodings, the controller FSM state type and a size legality helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // True for the three encodings that name a real access size.
  function automatic logic size_legal(input logic [1:0] size);
    return (size != SZ_ILL);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory controller.
// Store path: merges right-aligned write data into the addressed lanes of
// the old word, preserving all other lanes. Load path: extracts the
// addressed byte/half and zero- or sign-extends it to the full word.
// Lanes are little-endian; a half access ignores the lowest offset bit.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  offset,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] loaded
);

  localparam int BYTES     = DATA_W / 8;
  localparam int HALVES    = DATA_W / 16;
  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;
  localparam logic [DATA_W-1:0] ONES  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZEROS = {DATA_W{1'b0}};

  logic [7:0]       byte_val_s;
  logic [15:0]      half_val_s;
  logic [OFF_W-1:0] half_sel_s;

  // Lane selection, store merge and load extension for the requested size.
  always_comb begin
    merged     = old_word;
    loaded     = ZEROS;
    byte_val_s = 8'h00;
    half_val_s = 16'h0000;
    half_sel_s = offset >> 1;
    for (int i = 0; i < BYTES; i++) begin
      byte_val_s = (offset == OFF_W'(i)) ? old_word[i*8 +: 8] : byte_val_s;
    end
    for (int i = 0; i < HALVES; i++) begin
      half_val_s = (half_sel_s == OFF_W'(i)) ? old_word[i*16 +: 16] : half_val_s;
    end
    case (size)
      SZ_BYTE: begin
        for (int i = 0; i < BYTES; i++) begin
          merged[i*8 +: 8] = (offset == OFF_W'(i)) ? wdata[7:0] : old_word[i*8 +: 8];
        end
        loaded = DATA_W'(byte_val_s) |
                 ((!is_unsigned && byte_val_s[7]) ? (ONES << BYTE_BITS) : ZEROS);
      end
      SZ_HALF: begin
        for (int i = 0; i < HALVES; i++) begin
          merged[i*16 +: 16] = (half_sel_s == OFF_W'(i)) ? wdata[15:0] : old_word[i*16 +: 16];
        end
        loaded = DATA_W'(half_val_s) |
                 ((!is_unsigned && half_val_s[15]) ? (ONES << HALF_BITS) : ZEROS);
      end
      SZ_WORD: begin
        merged = wdata;
        loaded = old_word;
      end
      default: begin
        merged = old_word;
        loaded = ZEROS;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-port word memory behind a valid/ready
// request interface with a fixed-latency one-cycle response pulse.
// Stores commit and load data is captured at the acceptance edge; the
// response appears WAIT_CYC+1 cycles later and its data/error hold until
// the next response.
// Optional build macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses are rejected with rsp_err; otherwise the low address
// bits are ignored and the access is aligned down.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2,
  parameter int TEST_IDX = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       test_value
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [DATA_W-1:0] ZEROS = {DATA_W{1'b0}};

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              accept_s;
  logic [31:0]       word_idx_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [OFF_W-1:0]  offset_s;
  logic              misalign_s;
  logic              err_s;
  logic [DATA_W-1:0] old_word_s;
  logic [DATA_W-1:0] merged_s;
  logic [DATA_W-1:0] loaded_s;
  logic [DATA_W-1:0] rsp_data_s;

  logic [DATA_W-1:0] pend_rdata_r;
  logic              pend_err_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;

  assign offset_s   = req_addr[OFF_W-1:0];
  assign word_idx_s = req_addr >> OFF_W;
  assign in_range_s = (word_idx_s < 32'(DEPTH));
  assign mem_idx_s  = word_idx_s[IDX_W-1:0];
  assign old_word_s = in_range_s ? mem_r[mem_idx_s] : ZEROS;
  assign accept_s   = req_valid && (state_r == IDLE);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_s = ((req_size == SZ_HALF) && offset_s[0]) ||
                      ((req_size == SZ_WORD) && (offset_s != {OFF_W{1'b0}}));
`else
  assign misalign_s = 1'b0;
`endif

  assign err_s      = !size_legal(req_size) || !in_range_s || misalign_s;
  assign rsp_data_s = (err_s || req_we) ? ZEROS : loaded_s;

  dmem_lane_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .old_word    (old_word_s),
    .wdata       (req_wdata),
    .size        (req_size),
    .offset      (offset_s),
    .is_unsigned (req_unsigned),
    .merged      (merged_s),
    .loaded      (loaded_s)
  );

  // FSM state and wait down-counter registers.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: accept in IDLE, count WAIT_CYC cycles, pulse RESP once.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYC > 0) begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end else begin
            state_nxt_s = RESP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Capture the result at acceptance and publish it when entering RESP.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pend_rdata_r <= ZEROS;
      pend_err_r   <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= ZEROS;
      rsp_err_r    <= 1'b0;
    end else begin
      rsp_valid_r <= (state_nxt_s == RESP);
      if (accept_s) begin
        pend_rdata_r <= rsp_data_s;
        pend_err_r   <= err_s;
      end
      if ((state_r == IDLE) && (state_nxt_s == RESP)) begin
        rsp_rdata_r <= rsp_data_s;
        rsp_err_r   <= err_s;
      end else if ((state_r == WAIT) && (state_nxt_s == RESP)) begin
        rsp_rdata_r <= pend_rdata_r;
        rsp_err_r   <= pend_err_r;
      end
    end
  end

  // Memory array: cleared on reset, written by accepted legal stores.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ZEROS;
      end
    end else if (accept_s && req_we && !err_s) begin
      mem_r[mem_idx_s] <= merged_s;
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_err    = rsp_err_r;
  assign test_value = mem_r[TEST_IDX][15:0];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a WAIT_CYC=2 instance and a WAIT_CYC=0
// instance share clock and reset. Expected responses are queued at the
// acceptance edge and popped when rsp_valid is observed.
module tb_data_mem_ctrl;

  logic        CLK;
  logic        Reset;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] test_value;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [15:0] b_test_value;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic misalign_trap;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_CYC(2), .TEST_IDX(0)) u_dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .test_value(test_value)
  );

  data_mem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_CYC(0), .TEST_IDX(2)) u_dut0 (
    .CLK(CLK), .Reset(Reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .test_value(b_test_value)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance sel (0: WAIT_CYC=2, 1: WAIT_CYC=0); called at a negedge.
  task automatic do_req(input logic sel, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int   n;
    int   lat;
    exp_t e;
    logic rdy, vld;
    logic [31:0] held;
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_size = size;
      b_req_unsigned = uns; b_req_addr = addr; b_req_wdata = wdata;
    end else begin
      req_valid = 1'b1; req_we = we; req_size = size;
      req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    end
    n = 0;
    rdy = sel ? b_req_ready : req_ready;
    while (!rdy && n < 20) begin
      @(negedge CLK);
      n++;
      rdy = sel ? b_req_ready : req_ready;
    end
    chk({31'd0, rdy}, 32'd1, {tag, "_ready"});
    @(posedge CLK);
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge CLK);
    if (sel) begin
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_wdata = 32'hA5A5A5A5;
    end else begin
      req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'hA5A5A5A5;
    end
    lat = 1;
    vld = sel ? b_rsp_valid : rsp_valid;
    while (!vld && lat < 20) begin
      @(negedge CLK);
      lat++;
      vld = sel ? b_rsp_valid : rsp_valid;
    end
    chk({31'd0, vld}, 32'd1, {tag, "_rsp_valid"});
    chk(32'(lat), sel ? 32'd1 : 32'd3, {tag, "_latency"});
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      held = sel ? b_rsp_rdata : rsp_rdata;
      chk(held, e.rdata, {tag, "_rdata"});
      chk({31'd0, (sel ? b_rsp_err : rsp_err)}, {31'd0, e.err}, {tag, "_err"});
    end else begin
      chk(32'd0, 32'd1, {tag, "_scoreboard_empty"});
    end
    @(negedge CLK);
    chk({31'd0, (sel ? b_rsp_valid : rsp_valid)}, 32'd0, {tag, "_pulse_end"});
    chk(sel ? b_rsp_rdata : rsp_rdata, held, {tag, "_rdata_hold"});
  endtask

  initial begin
    logic saw_rsp;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign_trap = 1'b1;
`else
    misalign_trap = 1'b0;
`endif
    Reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b00; b_req_unsigned = 1'b0;
    b_req_addr = 32'd0; b_req_wdata = 32'd0;

    // Reset state
    @(negedge CLK);
    chk({31'd0, req_ready}, 32'd1, "rst_ready");
    chk({31'd0, rsp_valid}, 32'd0, "rst_rsp_valid");
    chk(rsp_rdata, 32'd0, "rst_rdata");
    chk({31'd0, rsp_err}, 32'd0, "rst_err");
    chk({16'd0, test_value}, 32'd0, "rst_test_value");
    Reset = 1'b1;
    @(negedge CLK);

    // Load of cleared memory
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h00000000, 1'b0, "ld_w0_init");
    chk({16'd0, test_value}, 32'd0, "tv_init");

    // Word store, byte/half loads with both extensions
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 32'd0, 1'b0, "st_w0");
    chk({16'd0, test_value}, 32'h0000BEEF, "tv_beef");
    do_req(1'b0, 1'b0, 2'b00, 1'b0, 32'd1, 32'd0, 32'hFFFFFFBE, 1'b0, "ld_b1_s");
    do_req(1'b0, 1'b0, 2'b00, 1'b1, 32'd1, 32'd0, 32'h000000BE, 1'b0, "ld_b1_u");
    do_req(1'b0, 1'b0, 2'b01, 1'b1, 32'd2, 32'd0, 32'h0000DEAD, 1'b0, "ld_h2_u");
    do_req(1'b0, 1'b0, 2'b01, 1'b0, 32'd2, 32'd0, 32'hFFFFDEAD, 1'b0, "ld_h2_s");
    do_req(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'hFFFFFFEF, 1'b0, "ld_b0_s");

    // Byte store preserves other lanes; upper wdata bits ignored
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'd3, 32'h1234565A, 32'd0, 1'b0, "st_b3");
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h5AADBEEF, 1'b0, "ld_w0_b3");

    // Half store into upper half of word 0
    do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'd2, 32'hFFFF7711, 32'd0, 1'b0, "st_h2");
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h7711BEEF, 1'b0, "ld_w0_h2");

    // Last legal word, then out-of-range accesses
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'd1020, 32'h11223344, 32'd0, 1'b0, "st_w_last");
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd1020, 32'd0, 32'h11223344, 1'b0, "ld_w_last");
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, "ld_oor");
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hFFFFFFFF, 32'd0, 1'b1, "st_oor");
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h7711BEEF, 1'b0, "ld_w0_after_oor");

    // Illegal size
    do_req(1'b0, 1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, "ld_sz11");
    do_req(1'b0, 1'b1, 2'b11, 1'b0, 32'd0, 32'h0BADF00D, 32'd0, 1'b1, "st_sz11");

    // Misaligned word store at addr 2
    if (misalign_trap) begin
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'd2, 32'hCAFEF00D, 32'd0, 1'b1, "st_w2_mis");
      do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h7711BEEF, 1'b0, "ld_w0_mis");
      chk({16'd0, test_value}, 32'h0000BEEF, "tv_mis");
    end else begin
      do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'd2, 32'hCAFEF00D, 32'd0, 1'b0, "st_w2_mis");
      do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'hCAFEF00D, 1'b0, "ld_w0_mis");
      chk({16'd0, test_value}, 32'h0000F00D, "tv_mis");
    end

    // Zero-wait instance: one-cycle latency, TEST_IDX=2 (byte addr 8)
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'd8, 32'h00C0FFEE, 32'd0, 1'b0, "z_st_w8");
    chk({16'd0, b_test_value}, 32'h0000FFEE, "z_tv");
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'd10, 32'd0, 32'hFFFFFFC0, 1'b0, "z_ld_b10");
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'd2048, 32'd0, 32'd0, 1'b1, "z_ld_oor");

    // Reset pulse during WAIT abandons the request
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'd0;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk({31'd0, req_ready}, 32'd0, "mid_busy");
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    chk({31'd0, req_ready}, 32'd1, "mid_ready_release");
    saw_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw_rsp = saw_rsp | rsp_valid;
      @(negedge CLK);
    end
    chk({31'd0, saw_rsp}, 32'd0, "mid_no_rsp");
    chk({31'd0, req_ready}, 32'd1, "mid_ready_idle");
    chk({16'd0, test_value}, 32'd0, "mid_tv_cleared");
    chk(rsp_rdata, 32'd0, "mid_rdata_cleared");
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h00000000, 1'b0, "ld_w0_cleared");

    chk(32'(sb_q.size()), 32'd0, "sb_drained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits (multiple of 16).
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning memory size in words.
REQ-003 The block SHALL have parameter WAIT_CYC, default 2, meaning extra wait cycles between acceptance and response (0..15).
REQ-004 The block SHALL have parameter TEST_IDX, default 0, meaning the word index whose low 16 bits drive test_value.
REQ-005 The block SHALL have port CLK, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1, meaning a synchronous, active-low reset.
REQ-007 The block SHALL have port req_valid, input, 1, meaning a request is presented.
REQ-008 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-009 The block SHALL have port req_we, input, 1, meaning the request is a store (1) or a load (0).
REQ-010 The block SHALL have port req_size, input, 2, meaning access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-011 The block SHALL have port req_unsigned, input, 1, meaning loads zero-extend (1) or sign-extend (0).
REQ-012 The block SHALL have port req_addr, input, 32, meaning the byte address.
REQ-013 The block SHALL have port req_wdata, input, DATA_W, meaning store data, right-aligned.
REQ-014 The block SHALL have port rsp_valid, output, 1, meaning a one-cycle response pulse.
REQ-015 The block SHALL have port rsp_rdata, output, DATA_W, meaning extended load data (0 for stores).
REQ-016 The block SHALL have port rsp_err, output, 1, meaning the request failed, qualified by rsp_valid.
REQ-017 The block SHALL have port test_value, output, 16, meaning the live low 16 bits of word TEST_IDX.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Acceptance SHALL occur on an edge where req_valid and req_ready are both 1; at that edge the FSM SHALL go to WAIT if WAIT_CYC>0, else to RESP.
REQ-020 WAIT SHALL last exactly WAIT_CYC cycles, counted by a down-counter, then go to RESP.
REQ-021 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; accept-to-rsp_valid latency is WAIT_CYC+1 cycles, and back-to-back throughput is one request per WAIT_CYC+2 cycles.
REQ-022 Stores SHALL commit at the acceptance edge, and load data SHALL be captured at the acceptance edge, so a load accepted after a store observes the stored data.
REQ-023 Byte lanes SHALL be little-endian: a byte access uses addr[1:0], and a half access uses addr[1]; unaddressed lanes SHALL be preserved on stores.
REQ-024 Word index SHALL be addr>>log2(DATA_W/8); an index >= DEPTH or req_size=11 SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-025 rsp_rdata and rsp_err SHALL hold their values until the next response; req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-026 On an edge with Reset=0, the block SHALL set: FSM=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all memory words=0, and hence test_value=0.
REQ-027 Reset asserted mid-operation SHALL abandon the request with no response pulse; req_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-028 With macro DMEM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-029 With DMEM_MISALIGN_TRAP_EN undefined, misaligned low address bits SHALL be ignored (access aligned down), with no error.

Structure
REQ-030 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-031 Sub-module dmem_lane_align SHALL be purely combinational, performing store merge (old word, wdata, size, offset) and load extract/extend.

Verification
REQ-032 Reset low 1 cycle, then read addr 0 -> rsp_valid on cycle 3 after acceptance (WAIT_CYC=2), with rdata=0x00000000, err=0, test_value=0.
REQ-033 Store word 0xDEADBEEF at addr 0, then load byte signed at addr 1 -> 0xFFFFFFBE, and load half unsigned at addr 2 -> 0x0000DEAD; test_value=0xBEEF.
REQ-034 Store byte 0x5A at addr 3 over 0xDEADBEEF, then load word -> 0x5AADBEEF.
REQ-035 Load word at addr 4*DEPTH -> err=1, rdata=0; a store to the same address leaves memory unchanged.
REQ-036 Word store at addr 2 -> err=1 with the macro defined; without it, the write goes to word 0 and err=0.
REQ-037 Reset pulse during WAIT -> no rsp_valid, and req_ready=1 one cycle after release; WAIT_CYC=0 build gives 1-cycle latency.
